// File: rtl/tcp_vlg_seg_tx_if.sv
// Handshake and data bundle for the TCP segment builder: descriptor, payload and output byte stream.
interface tcp_vlg_seg_tx_if;
    logic        hdr_val;
    logic        hdr_rdy;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
    logic [15:0] wnd;
    logic [15:0] pld_len;
    logic [7:0]  pld_dat;
    logic        pld_val;
    logic        pld_rdy;
    logic [7:0]  out_dat;
    logic        out_val;
    logic        out_sof;
    logic        out_eof;
    logic        out_rdy;
    logic        err;

    // Producer of descriptors/payload and consumer of the segment stream
    modport master (
        output hdr_val, src_ip, dst_ip, src_port, dst_port, seq, ack, flags, wnd, pld_len,
        output pld_dat, pld_val, out_rdy,
        input  hdr_rdy, pld_rdy, out_dat, out_val, out_sof, out_eof, err
    );

    // Segment builder side
    modport slave (
        input  hdr_val, src_ip, dst_ip, src_port, dst_port, seq, ack, flags, wnd, pld_len,
        input  pld_dat, pld_val, out_rdy,
        output hdr_rdy, pld_rdy, out_dat, out_val, out_sof, out_eof, err
    );
endinterface

// File: rtl/tcp_vlg_seg_tx.sv
// Transmit-side TCP segment builder: buffers one payload, computes the TCP checksum while
// loading, then streams the 20-byte header followed by the payload as a byte stream.
module tcp_vlg_seg_tx #(
    parameter int unsigned RAM_DEPTH = 12
) (
    input  logic            clk,
    input  logic            rst,
    tcp_vlg_seg_tx_if.slave bus
);
    localparam int unsigned AW       = RAM_DEPTH;
    localparam int unsigned RAM_SIZE = 2 ** RAM_DEPTH;
    localparam int unsigned HDR_LEN  = 20;
    localparam int unsigned HDR_LAST = HDR_LEN - 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FOLD, S_HDR, S_PLD} state_e;

    state_e        state_q;
    logic [15:0]   src_port_q, dst_port_q, wnd_q, len_q, idx_q, csum_q;
    logic [31:0]   seq_q, ack_q, acc_q;
    logic [7:0]    flags_q, hi_q, out_dat_q, ram_rd_q;
    logic          fold_q, hdr_rdy_q, pld_rdy_q, out_val_q, out_sof_q, out_eof_q, err_q;
    logic [7:0]    mem_q [RAM_SIZE];

    logic          hdr_acc_c, pld_acc_c, out_xfer_c, too_long_c, pld_last_c;
    logic [31:0]   pseudo_c, hdr_sum_c;
    logic [16:0]   fold1_c;
    logic [15:0]   fold2_c;
    logic [4:0]    hdr_sel_c;
    logic [7:0]    hdr_nxt_c;
    logic [AW-1:0] rd_addr_c;

    // Handshakes, pseudo-header seed, header word sum and end-around-carry folding
    always_comb begin
        hdr_acc_c  = bus.hdr_val && hdr_rdy_q;
        pld_acc_c  = bus.pld_val && pld_rdy_q;
        out_xfer_c = out_val_q && bus.out_rdy;
        too_long_c = 32'(bus.pld_len) > RAM_SIZE;
        pld_last_c = (idx_q == (len_q - 16'd1));
        pseudo_c   = 32'(bus.src_ip[31:16]) + 32'(bus.src_ip[15:0])
                   + 32'(bus.dst_ip[31:16]) + 32'(bus.dst_ip[15:0])
                   + 32'd6 + 32'(HDR_LEN) + 32'(bus.pld_len);
        hdr_sum_c  = 32'(src_port_q) + 32'(dst_port_q)
                   + 32'(seq_q[31:16]) + 32'(seq_q[15:0])
                   + 32'(ack_q[31:16]) + 32'(ack_q[15:0])
                   + 32'({8'h50, flags_q}) + 32'(wnd_q);
        fold1_c    = 17'(acc_q[31:16]) + 17'(acc_q[15:0]);
        fold2_c    = fold1_c[15:0] + 16'(fold1_c[16]);
    end

    // Next header byte to present (byte 0 is loaded directly when leaving FOLD)
    always_comb begin
        hdr_sel_c = 5'(idx_q) + 5'd1;
        hdr_nxt_c = 8'h00;
        case (hdr_sel_c)
            5'd1:    hdr_nxt_c = src_port_q[7:0];
            5'd2:    hdr_nxt_c = dst_port_q[15:8];
            5'd3:    hdr_nxt_c = dst_port_q[7:0];
            5'd4:    hdr_nxt_c = seq_q[31:24];
            5'd5:    hdr_nxt_c = seq_q[23:16];
            5'd6:    hdr_nxt_c = seq_q[15:8];
            5'd7:    hdr_nxt_c = seq_q[7:0];
            5'd8:    hdr_nxt_c = ack_q[31:24];
            5'd9:    hdr_nxt_c = ack_q[23:16];
            5'd10:   hdr_nxt_c = ack_q[15:8];
            5'd11:   hdr_nxt_c = ack_q[7:0];
            5'd12:   hdr_nxt_c = 8'h50;
            5'd13:   hdr_nxt_c = flags_q;
            5'd14:   hdr_nxt_c = wnd_q[15:8];
            5'd15:   hdr_nxt_c = wnd_q[7:0];
            5'd16:   hdr_nxt_c = csum_q[15:8];
            5'd17:   hdr_nxt_c = csum_q[7:0];
            default: hdr_nxt_c = 8'h00;
        endcase
    end

    // Read address keeps ram_rd_q one byte ahead of the byte being presented
    always_comb begin
        rd_addr_c = '0;
        if (state_q == S_PLD) begin
            rd_addr_c = out_xfer_c ? AW'(idx_q + 16'd2) : AW'(idx_q + 16'd1);
        end else if (state_q == S_HDR && out_xfer_c && idx_q == 16'(HDR_LAST)) begin
            rd_addr_c = AW'(16'd1);
        end
    end

    // Payload buffer: write while loading, synchronous read every cycle
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && pld_acc_c) begin
            mem_q[AW'(idx_q)] <= bus.pld_dat;
        end
        ram_rd_q <= mem_q[rd_addr_c];
    end

    // Segment FSM with registered handshake and output signals
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hdr_rdy_q  <= 1'b1;
            pld_rdy_q  <= 1'b0;
            out_val_q  <= 1'b0;
            out_sof_q  <= 1'b0;
            out_eof_q  <= 1'b0;
            err_q      <= 1'b0;
            out_dat_q  <= 8'h00;
            acc_q      <= 32'h0;
            idx_q      <= 16'h0;
            fold_q     <= 1'b0;
            csum_q     <= 16'h0;
            hi_q       <= 8'h00;
            src_port_q <= 16'h0;
            dst_port_q <= 16'h0;
            seq_q      <= 32'h0;
            ack_q      <= 32'h0;
            flags_q    <= 8'h00;
            wnd_q      <= 16'h0;
            len_q      <= 16'h0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hdr_acc_c) begin
                        if (too_long_c) begin
                            err_q <= 1'b1;
                        end else begin
                            src_port_q <= bus.src_port;
                            dst_port_q <= bus.dst_port;
                            seq_q      <= bus.seq;
                            ack_q      <= bus.ack;
                            flags_q    <= bus.flags;
                            wnd_q      <= bus.wnd;
                            len_q      <= bus.pld_len;
                            acc_q      <= pseudo_c;
                            idx_q      <= 16'h0;
                            fold_q     <= 1'b0;
                            hdr_rdy_q  <= 1'b0;
                            if (bus.pld_len == 16'd0) begin
                                state_q <= S_FOLD;
                            end else begin
                                state_q   <= S_LOAD;
                                pld_rdy_q <= 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (pld_acc_c) begin
                        idx_q <= idx_q + 16'd1;
                        if (idx_q[0]) begin
                            acc_q <= acc_q + 32'({hi_q, bus.pld_dat});
                        end else begin
                            hi_q <= bus.pld_dat;
                            if (pld_last_c) begin
                                acc_q <= acc_q + 32'({bus.pld_dat, 8'h00});
                            end
                        end
                        if (pld_last_c) begin
                            pld_rdy_q <= 1'b0;
                            state_q   <= S_FOLD;
                        end
                    end
                end
                S_FOLD: begin
                    if (!fold_q) begin
                        acc_q  <= acc_q + hdr_sum_c;
                        fold_q <= 1'b1;
                    end else begin
                        csum_q    <= ~fold2_c;
                        idx_q     <= 16'h0;
                        out_val_q <= 1'b1;
                        out_sof_q <= 1'b1;
                        out_eof_q <= 1'b0;
                        out_dat_q <= src_port_q[15:8];
                        state_q   <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (out_xfer_c) begin
                        out_sof_q <= 1'b0;
                        if (idx_q == 16'(HDR_LAST)) begin
                            if (len_q == 16'd0) begin
                                out_val_q <= 1'b0;
                                out_eof_q <= 1'b0;
                                hdr_rdy_q <= 1'b1;
                                state_q   <= S_IDLE;
                            end else begin
                                idx_q     <= 16'h0;
                                out_dat_q <= ram_rd_q;
                                out_eof_q <= (len_q == 16'd1);
                                state_q   <= S_PLD;
                            end
                        end else begin
                            idx_q     <= idx_q + 16'd1;
                            out_dat_q <= hdr_nxt_c;
                            out_eof_q <= (idx_q == 16'(HDR_LAST - 1)) && (len_q == 16'd0);
                        end
                    end
                end
                S_PLD: begin
                    if (out_xfer_c) begin
                        if (out_eof_q) begin
                            out_val_q <= 1'b0;
                            out_eof_q <= 1'b0;
                            hdr_rdy_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            idx_q     <= idx_q + 16'd1;
                            out_dat_q <= ram_rd_q;
                            out_eof_q <= ((idx_q + 16'd2) == len_q);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.hdr_rdy = hdr_rdy_q;
    assign bus.pld_rdy = pld_rdy_q;
    assign bus.out_dat = out_dat_q;
    assign bus.out_val = out_val_q;
    assign bus.out_sof = out_sof_q;
    assign bus.out_eof = out_eof_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_tcp_vlg_seg_tx.sv
// Testbench for tcp_vlg_seg_tx: random descriptors/payloads against a byte-level segment model.
module tb_tcp_vlg_seg_tx;
    localparam int unsigned RAM_DEPTH = 12;
    localparam int unsigned MAX_LEN   = 2 ** RAM_DEPTH;
    localparam int          BUDGET    = 20000;

    typedef struct {
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [7:0]  flags;
        logic [15:0] wnd;
        logic [15:0] len;
    } desc_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    bit   tmo = 1'b0;

    desc_t      dq[$];
    logic [7:0] pay_all[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic [9:0] ref_q[$];
    int         acc_cyc[8];
    int         done_cyc[8];
    int         first_cyc[8];
    int         eof_cyc[8];

    tcp_vlg_seg_tx_if bus();

    tcp_vlg_seg_tx #(.RAM_DEPTH(RAM_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic desc_t mk(input logic [31:0] sip, input logic [31:0] dip,
                                 input logic [15:0] sp, input logic [15:0] dp,
                                 input logic [31:0] seq, input logic [31:0] ack,
                                 input logic [7:0] flags, input logic [15:0] wnd,
                                 input logic [15:0] len);
        desc_t d;
        d.sip = sip; d.dip = dip; d.sp = sp; d.dp = dp; d.seq = seq; d.ack = ack;
        d.flags = flags; d.wnd = wnd; d.len = len;
        return d;
    endfunction

    function automatic desc_t rnd_desc(input int len);
        return mk($urandom, $urandom, 16'($urandom), 16'($urandom), $urandom, $urandom,
                  8'($urandom), 16'($urandom), 16'(len));
    endfunction

    // Header byte i of a segment as it appears on the wire
    function automatic logic [7:0] hdr_byte(input desc_t d, input logic [15:0] cs, input int i);
        logic [159:0] h;
        h = {d.sp, d.dp, d.seq, d.ack, 8'h50, d.flags, d.wnd, cs, 16'h0000};
        return h[159 - 8*i -: 8];
    endfunction

    // One's-complement checksum over pseudo-header, zero-checksum header and padded payload
    function automatic logic [15:0] ref_csum(input desc_t d, input int off);
        logic [95:0] ph;
        int unsigned s;
        logic [7:0]  hi;
        logic [7:0]  lo;
        ph = {d.sip, d.dip, 8'h00, 8'h06, 16'(20 + int'(d.len))};
        s = 0;
        for (int i = 0; i < 6; i++) s += 32'(ph[95 - 16*i -: 16]);
        for (int i = 0; i < 10; i++) s += 32'({hdr_byte(d, 16'h0, 2*i), hdr_byte(d, 16'h0, 2*i + 1)});
        for (int i = 0; i < int'(d.len); i += 2) begin
            hi = pay_all[off + i];
            lo = (i + 1 < int'(d.len)) ? pay_all[off + i + 1] : 8'h00;
            s += 32'({hi, lo});
        end
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic model_seg(input desc_t d, input int off);
        logic [15:0] cs;
        logic [7:0]  b;
        int          total;
        cs = ref_csum(d, off);
        total = 20 + int'(d.len);
        for (int i = 0; i < total; i++) begin
            b = (i < 20) ? hdr_byte(d, cs, i) : pay_all[off + i - 20];
            exp_q.push_back({i == 0, i == total - 1, b});
        end
    endtask

    task automatic put_desc(input desc_t d);
        bus.src_ip = d.sip; bus.dst_ip = d.dip; bus.src_port = d.sp; bus.dst_port = d.dp;
        bus.seq = d.seq; bus.ack = d.ack; bus.flags = d.flags; bus.wnd = d.wnd; bus.pld_len = d.len;
    endtask

    task automatic drv_hdr();
        int n = 0;
        foreach (dq[k]) begin
            put_desc(dq[k]);
            bus.hdr_val = 1'b1;
            while (!bus.hdr_rdy && !tmo) begin
                @(posedge clk); #1;
                if (++n > BUDGET) begin
                    tmo = 1'b1;
                    check("timeout_hdr", 32'(k), 32'(dq.size()));
                end
            end
            if (tmo) begin
                bus.hdr_val = 1'b0;
                return;
            end
            acc_cyc[k] = cyc;
            if (dq[k].len == 16'd0) done_cyc[k] = cyc;
            @(posedge clk); #1;
        end
        bus.hdr_val = 1'b0;
    endtask

    task automatic drv_pld(input bit rnd);
        int n = 0;
        int off = 0;
        bit done;
        foreach (dq[k]) begin
            for (int i = 0; i < int'(dq[k].len); i++) begin
                done = 1'b0;
                bus.pld_dat = pay_all[off + i];
                while (!done && !tmo) begin
                    bus.pld_val = rnd ? ($urandom_range(3) != 0) : 1'b1;
                    if (bus.pld_val && bus.pld_rdy) begin
                        done = 1'b1;
                        done_cyc[k] = cyc;
                    end
                    @(posedge clk); #1;
                    if (++n > BUDGET) begin
                        tmo = 1'b1;
                        check("timeout_pld", 32'(i), 32'(dq[k].len));
                    end
                end
                if (tmo) begin
                    bus.pld_val = 1'b0;
                    return;
                end
            end
            off += int'(dq[k].len);
        end
        bus.pld_val = 1'b0;
    endtask

    task automatic mon(input bit rnd, input int nseg);
        int         seg = 0;
        int         n = 0;
        bit         want = 1'b1;
        bit         stall = 1'b0;
        logic [9:0] held = '0;
        while (seg < nseg && !tmo) begin
            bus.out_rdy = rnd ? 1'($urandom_range(1)) : 1'b1;
            if (stall) begin
                check("hold_val", 32'(bus.out_val), 32'd1);
                check("hold_dat", 32'({bus.out_sof, bus.out_eof, bus.out_dat}), 32'(held));
            end
            stall = 1'b0;
            if (bus.out_val) begin
                if (want) begin
                    first_cyc[seg] = cyc;
                    want = 1'b0;
                end
                held = {bus.out_sof, bus.out_eof, bus.out_dat};
                if (bus.out_rdy) begin
                    got_q.push_back(held);
                    if (bus.out_eof) begin
                        eof_cyc[seg] = cyc;
                        seg++;
                        want = 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (++n > BUDGET) begin
                tmo = 1'b1;
                check("timeout_out", 32'(seg), 32'(nseg));
            end
        end
        bus.out_rdy = 1'b0;
    endtask

    // Drive every descriptor in dq with its payload and compare the stream with the model
    task automatic run(input bit rnd);
        int n;
        int off = 0;
        n = dq.size();
        exp_q.delete();
        got_q.delete();
        foreach (dq[k]) begin
            model_seg(dq[k], off);
            off += int'(dq[k].len);
        end
        fork
            drv_hdr();
            drv_pld(rnd);
            mon(rnd, n);
        join
        check("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        if (!tmo) begin
            for (int k = 0; k < n; k++) begin
                check($sformatf("latency%0d", k), 32'(first_cyc[k] - done_cyc[k]), 32'd3);
                if (k > 0) check($sformatf("b2b%0d", k), 32'(acc_cyc[k] > eof_cyc[k - 1]), 32'd1);
            end
        end
    endtask

    task automatic rnd_payload(input int len);
        for (int i = 0; i < len; i++) pay_all.push_back(8'($urandom));
    endtask

    initial begin
        logic [9:0] e;
        int         cnt;
        int         n;
        bit         any;

        rst = 1'b1;
        bus.hdr_val = 1'b0; bus.pld_val = 1'b0; bus.pld_dat = 8'h00; bus.out_rdy = 1'b0;
        put_desc(mk(32'h0, 32'h0, 16'h0, 16'h0, 32'h0, 32'h0, 8'h00, 16'h0, 16'h0));
        repeat (3) @(posedge clk);
        #1;
        check("rst_hdr_rdy", 32'(bus.hdr_rdy), 32'd1);
        check("rst_pld_rdy", 32'(bus.pld_rdy), 32'd0);
        check("rst_out_val", 32'(bus.out_val), 32'd0);
        check("rst_out_sof", 32'(bus.out_sof), 32'd0);
        check("rst_out_eof", 32'(bus.out_eof), 32'd0);
        check("rst_err",     32'(bus.err),     32'd0);
        check("rst_out_dat", 32'(bus.out_dat), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // SYN segment, no payload
        dq = {mk(32'hC0A80101, 32'hC0A80102, 16'h1F90, 16'h0050, 32'h12345678, 32'h0,
                 8'h02, 16'hFFFF, 16'd0)};
        pay_all.delete();
        run(1'b0);
        if (got_q.size() == 20) begin
            e = got_q[12]; check("t1_byte12", 32'(e[7:0]), 32'h50);
            e = got_q[13]; check("t1_byte13", 32'(e[7:0]), 32'h02);
            e = got_q[19]; check("t1_eof19", 32'(e[8]), 32'd1);
        end

        // Odd payload "abc"
        pay_all = {8'h61, 8'h62, 8'h63};
        dq = {mk(32'h0A000001, 32'h0A000002, 16'd40000, 16'd80, 32'hDEADBEEF, 32'h01020304,
                 8'h18, 16'h2000, 16'd3)};
        run(1'b1);

        // 1460-byte payload, no-stall reference then random out_rdy
        pay_all.delete();
        rnd_payload(1460);
        dq = {rnd_desc(1460)};
        run(1'b0);
        ref_q = got_q;
        run(1'b1);
        check("t3_size", 32'(got_q.size()), 32'(ref_q.size()));
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            check($sformatf("t3_same%0d", i), 32'(got_q[i]), 32'(ref_q[i]));

        // Oversized descriptor is rejected
        put_desc(rnd_desc(MAX_LEN + 1));
        bus.hdr_val = 1'b1;
        check("t4_rdy_pre", 32'(bus.hdr_rdy), 32'd1);
        @(posedge clk); #1;
        bus.hdr_val = 1'b0;
        check("t4_err", 32'(bus.err), 32'd1);
        check("t4_rdy", 32'(bus.hdr_rdy), 32'd1);
        @(posedge clk); #1;
        check("t4_err_clr", 32'(bus.err), 32'd0);
        any = 1'b0;
        repeat (20) begin
            any |= bus.out_val | bus.pld_rdy;
            @(posedge clk); #1;
        end
        check("t4_quiet", 32'(any), 32'd0);

        // Largest payload the buffer holds
        pay_all.delete();
        rnd_payload(MAX_LEN);
        dq = {rnd_desc(MAX_LEN)};
        run(1'b0);

        // Back-to-back descriptors held valid, plus random mixes
        for (int t = 0; t < 5; t++) begin
            int l0, l1, l2;
            l0 = (t == 0) ? 5 : $urandom_range(40);
            l1 = (t == 0) ? 0 : $urandom_range(40);
            l2 = (t == 0) ? 1 : $urandom_range(3);
            pay_all.delete();
            rnd_payload(l0); rnd_payload(l1); rnd_payload(l2);
            dq = {rnd_desc(l0), rnd_desc(l1), rnd_desc(l2)};
            run(t != 0);
        end

        // Reset while header byte 7 is on the bus
        pay_all.delete();
        rnd_payload(6);
        dq = {rnd_desc(6)};
        fork
            drv_hdr();
            drv_pld(1'b0);
        join
        bus.out_rdy = 1'b1;
        cnt = 0;
        n = 0;
        while (!(bus.out_val && cnt == 7) && n < 200) begin
            if (bus.out_val) cnt++;
            @(posedge clk); #1;
            n++;
        end
        check("t6_reach", 32'(cnt), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_out_val", 32'(bus.out_val), 32'd0);
        check("t6_hdr_rdy", 32'(bus.hdr_rdy), 32'd1);
        check("t6_pld_rdy", 32'(bus.pld_rdy), 32'd0);
        any = 1'b0;
        repeat (10) begin
            any |= bus.out_val;
            @(posedge clk); #1;
        end
        check("t6_no_resume", 32'(any), 32'd0);
        bus.out_rdy = 1'b0;
        pay_all.delete();
        rnd_payload(9);
        dq = {rnd_desc(9)};
        run(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
